if_id_stage: RTL and testbench
==============================

# if_id_stage

IF/ID pipeline register for the 64-bit RISC-V pipelined core. Captures the fetch-stage PC and instruction word each cycle and presents them, with pre-split decode fields, to the decode stage. Hazard control holds it with `id_write`, deasserted in the same cycle the PC's write enable is deasserted. Branch and jump resolution clear it with `flush`, which replaces the held instruction with a NOP bubble.

## Interface
Parameters:
- `XLEN`, 64, PC width in bits.
- `NOP_INSTR`, 32'h00000013, word loaded on flush or reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_pc`  in  XLEN  PC of the instruction being fetched (program counter output).
- `if_instr`  in  32  instruction word read at `if_pc`.
- `if_valid`  in  1  fetch slot holds a real instruction.
- `id_write`  in  1  1 = load new values; 0 = hold (stall).
- `flush`  in  1  1 = discard the current fetch and insert a bubble.
- `id_pc`  out  XLEN  registered PC.
- `id_pc_plus4`  out  XLEN  registered `if_pc + 4`, modulo 2^XLEN.
- `id_instr`  out  32  registered instruction word.
- `id_valid`  out  1  registered valid.
- `id_opcode`  out  7  `id_instr[6:0]`.
- `id_rd`  out  5  `id_instr[11:7]`.
- `id_funct3`  out  3  `id_instr[14:12]`.
- `id_rs1`  out  5  `id_instr[19:15]`.
- `id_rs2`  out  5  `id_instr[24:20]`.
- `id_funct7`  out  7  `id_instr[31:25]`.
- `stall_count`  out  32  present only with `IF_ID_PERF_EN`.
- `flush_count`  out  32  present only with `IF_ID_PERF_EN`.

## Operation
Each rising edge, the first matching row of this priority list applies:
- **Reset**: `reset`=1.
  - `id_pc`=0, `id_pc_plus4`=4, `id_instr`=`NOP_INSTR`, `id_valid`=0.
  - Counters are set to 0.
- **Flush**: `flush`=1. Flush overrides a stall.
  - `id_instr`=`NOP_INSTR`, `id_valid`=0.
  - `id_pc` and `id_pc_plus4` load from `if_pc`.
  - `flush_count` increments.
- **Stall**: `id_write`=0.
  - All registers hold.
  - `stall_count` increments, but only when `id_valid`=1. Stalling a bubble is not counted.
- **Load**: `id_pc`←`if_pc`, `id_pc_plus4`←`if_pc+4`, `id_instr`←`if_instr`, `id_valid`←`if_valid`.
  - If `if_valid`=0, `id_instr` is forced to `NOP_INSTR`.

Rules for the decode fields and arithmetic:
- Decode fields are purely combinational slices of `id_instr`, never separately registered. A bubble therefore always decodes as opcode 7'h13, rd 0.
- `id_pc_plus4` wraps: `if_pc`=64'hFFFF_FFFF_FFFF_FFFC gives 0.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Latency is exactly one cycle from `if_*` to `id_*`. There is no combinational path from inputs to outputs.
- Stall semantics:
  - If `id_write` is low during cycle N, the outputs after edge N equal the outputs before it.
  - The upstream PC holds in the same cycle, so the instruction is not lost.
- Flush semantics:
  - If `flush` is high in cycle N, the edge ends with `id_valid`=0.
  - On the following edge, normal loading resumes from the redirected `if_pc`.
- Reset mid-stream:
  - A reset asserted in any cycle wins over `flush` and `id_write`.
  - Outputs take their reset values on that edge.
  - Loading resumes on the first edge with `reset`=0.
- Counters and data registers use the same edge. Counter outputs are registered values.

## Configuration
- Macro: `IF_ID_PERF_EN`.
- **Defined**:
  - The `stall_count` and `flush_count` ports and their registers exist, with the behaviour described under Operation.
- **Undefined**:
  - The ports and registers are absent.
  - Pipeline data behaviour is identical.

## Test plan
- Reset with `if_pc`=64'h100, `if_instr`=32'h00500093 driven -> after the edge: `id_pc`=0, `id_pc_plus4`=4, `id_instr`=32'h00000013, `id_valid`=0, `id_opcode`=7'h13.
- Load `if_pc`=64'h8, `if_instr`=32'h00A28233 (add x4,x5,x10), valid -> next cycle: `id_pc_plus4`=64'hC, `id_rd`=4, `id_rs1`=5, `id_rs2`=10, `id_funct7`=0, `id_valid`=1.
- Hold `id_write`=0 for 3 cycles while `if_*` changes -> outputs stay at the prior values; `stall_count`=3.
- Assert `flush`=1 and `id_write`=0 together with `if_pc`=64'h40 -> `id_instr`=32'h00000013, `id_valid`=0, `id_pc`=64'h40; `flush_count`=1; `stall_count` unchanged.
- Load `if_pc`=64'hFFFF_FFFF_FFFF_FFFC -> `id_pc_plus4`=0.
- Preload `stall_count`=32'hFFFF_FFFF by forcing the register, then stall a valid instruction -> count remains 32'hFFFF_FFFF. Separately, assert `reset` during a stall -> all outputs take reset values on that edge.

Source files
------------

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// if_id_stage : IF/ID pipeline register with pre-split decode fields.
// Optional stall/flush counters enabled by IF_ID_PERF_EN.   Rev 1.0
// ============================================================================
module if_id_stage #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            if_valid,
  input  logic            id_write,
  input  logic            flush,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr,
  output logic            id_valid,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [6:0]      id_funct7
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
`endif
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  logic [XLEN-1:0] w_pc_plus4;
  assign w_pc_plus4 = if_pc + C_PC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc       <= '0;
      id_pc_plus4 <= C_PC_STEP;
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_pc       <= if_pc;
      id_pc_plus4 <= w_pc_plus4;
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
    end else if (id_write) begin
      id_pc       <= if_pc;
      id_pc_plus4 <= w_pc_plus4;
      id_instr    <= if_valid ? if_instr : NOP_INSTR;
      id_valid    <= if_valid;
    end
  end

`ifdef IF_ID_PERF_EN
  // Counters saturate; stalling a bubble is not a lost cycle of real work.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
    end else if (!id_write && id_valid) begin
      if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end
`endif

  // Decode fields are slices of the registered word, so a bubble decodes as NOP.
  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_funct3 = id_instr[14:12];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign id_funct7 = id_instr[31:25];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// Scoreboard bench for if_id_stage: driver pushes hand-computed expectations,
// monitor pops one per clock after the edge and compares.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, flush, id_write, if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [63:0] id_pc, id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int checks = 0;
  int fails  = 0;
  int vec    = 0;

  typedef struct {
    int          idx;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  if_id_stage dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .id_write(id_write), .flush(flush),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_funct7(id_funct7)
`ifdef IF_ID_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Monitor: one registered result per edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    logic [31:0] ei;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ei = e.instr;
        chk("id_pc",       e.idx, id_pc,       e.pc);
        chk("id_pc_plus4", e.idx, id_pc_plus4, e.pc4);
        chk("id_instr",    e.idx, id_instr,    ei);
        chk("id_valid",    e.idx, id_valid,    e.valid);
        chk("id_opcode",   e.idx, id_opcode,   ei[6:0]);
        chk("id_rd",       e.idx, id_rd,       ei[11:7]);
        chk("id_funct3",   e.idx, id_funct3,   ei[14:12]);
        chk("id_rs1",      e.idx, id_rs1,      ei[19:15]);
        chk("id_rs2",      e.idx, id_rs2,      ei[24:20]);
        chk("id_funct7",   e.idx, id_funct7,   ei[31:25]);
`ifdef IF_ID_PERF_EN
        chk("stall_count", e.idx, stall_count, e.sc);
        chk("flush_count", e.idx, flush_count, e.fc);
`endif
      end
    end
  end

  task automatic drv(input logic rst, input logic fl, input logic wr, input logic v,
                     input logic [63:0] pc, input logic [31:0] ins,
                     input logic [63:0] epc, input logic [63:0] epc4,
                     input logic [31:0] ei, input logic ev,
                     input logic [31:0] esc, input logic [31:0] efc);
    exp_t e;
    @(negedge clk);
    reset = rst; flush = fl; id_write = wr; if_valid = v;
    if_pc = pc; if_instr = ins;
    e.idx = vec; e.pc = epc; e.pc4 = epc4; e.instr = ei; e.valid = ev;
    e.sc = esc; e.fc = efc;
    sb.push_back(e);
    vec++;
  endtask

  initial begin
    int budget;
    reset = 1'b1; flush = 1'b0; id_write = 1'b1; if_valid = 1'b1;
    if_pc = 64'h100; if_instr = 32'h00500093;
    //   rst fl wr v  if_pc      if_instr      exp pc    exp pc4   exp instr     v  sc fc
    drv(1, 0, 1, 1, 64'h100, 32'h00500093, 64'h0,   64'h4,   32'h00000013, 0, 0, 0);
    drv(0, 0, 1, 1, 64'h8,   32'h00A28233, 64'h8,   64'hC,   32'h00A28233, 1, 0, 0);
    drv(0, 0, 0, 1, 64'hC,   32'h00500093, 64'h8,   64'hC,   32'h00A28233, 1, 1, 0);
    drv(0, 0, 0, 1, 64'h10,  32'hDEADBEEF, 64'h8,   64'hC,   32'h00A28233, 1, 2, 0);
    drv(0, 0, 0, 0, 64'h14,  32'h12345678, 64'h8,   64'hC,   32'h00A28233, 1, 3, 0);
    drv(0, 1, 0, 1, 64'h40,  32'h00500093, 64'h40,  64'h44,  32'h00000013, 0, 3, 1);
    drv(0, 0, 0, 1, 64'h80,  32'h00A28233, 64'h40,  64'h44,  32'h00000013, 0, 3, 1);
    drv(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00500093,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h00500093, 1, 3, 1);
    drv(0, 0, 1, 0, 64'h20,  32'h00A28233, 64'h20,  64'h24,  32'h00000013, 0, 3, 1);
    drv(0, 0, 1, 1, 64'h24,  32'h00A28233, 64'h24,  64'h28,  32'h00A28233, 1, 3, 1);
    drv(0, 0, 0, 1, 64'h28,  32'h00500093, 64'h24,  64'h28,  32'h00A28233, 1, 4, 1);
    drv(1, 1, 0, 1, 64'h2C,  32'h00500093, 64'h0,   64'h4,   32'h00000013, 0, 0, 0);
    drv(0, 0, 1, 1, 64'h30,  32'h00500093, 64'h30,  64'h34,  32'h00500093, 1, 0, 0);
    drv(0, 1, 1, 1, 64'h50,  32'h00A28233, 64'h50,  64'h54,  32'h00000013, 0, 0, 1);
    drv(0, 0, 1, 1, 64'h54,  32'h00A28233, 64'h54,  64'h58,  32'h00A28233, 1, 0, 1);
`ifdef IF_ID_PERF_EN
    @(negedge clk);
    force dut.stall_count = 32'hFFFF_FFFF;
    #1 release dut.stall_count;
    drv(0, 0, 0, 1, 64'h58,  32'h00500093, 64'h54,  64'h58,  32'h00A28233, 1, 32'hFFFF_FFFF, 1);
`endif
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
